// File: rtl/msrv32_trap_pkg.sv
// Shared types and constants for the msrv32 machine-mode trap sequencer.
// Covers FSM states, mcause codes, PC-mux selects and SYSTEM-instruction decode fields.
package msrv32_trap_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_OPERATING,
    ST_TRAP_TAKEN,
    ST_TRAP_RETURN,
    ST_WFI_SLEEP
  } trap_state_t;

  localparam logic [4:0] CAUSE_INSTR_MISALIGNED = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL_INSTR    = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT       = 5'd3;
  localparam logic [4:0] CAUSE_LOAD_MISALIGNED  = 5'd4;
  localparam logic [4:0] CAUSE_STORE_MISALIGNED = 5'd6;
  localparam logic [4:0] CAUSE_ECALL_M          = 5'd11;
  localparam logic [4:0] CAUSE_MSI              = 5'd3;
  localparam logic [4:0] CAUSE_MTI              = 5'd7;
  localparam logic [4:0] CAUSE_MEI              = 5'd11;
  localparam logic [4:0] CAUSE_LIRQ_BASE        = 5'd16;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NEXT = 2'b11;

  localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
  localparam logic [2:0] FUNCT3_PRIV   = 3'b000;
  localparam logic [6:0] FUNCT7_ECALL  = 7'b0000000;
  localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;
  localparam logic [6:0] FUNCT7_WFI    = 7'b0001000;
  localparam logic [4:0] RS2_ECALL     = 5'd0;
  localparam logic [4:0] RS2_EBREAK    = 5'd1;
  localparam logic [4:0] RS2_MRET      = 5'd2;
  localparam logic [4:0] RS2_WFI       = 5'd5;

  // Privileged SYSTEM instructions all share opcode/funct3 and require rs1 = rd = x0.
  function automatic logic is_priv_instr(
    input logic [4:0] opcode,
    input logic [2:0] funct3,
    input logic [6:0] funct7,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic [4:0] rd,
    input logic [6:0] funct7_ref,
    input logic [4:0] rs2_ref
  );
    return (opcode == OPCODE_SYSTEM) && (funct3 == FUNCT3_PRIV) && (rs1 == 5'd0) &&
           (rd == 5'd0) && (funct7 == funct7_ref) && (rs2 == rs2_ref);
  endfunction

endpackage

// File: rtl/msrv32_trap_sequencer_if.sv
// Signal bundle between the decode/CSR side of the core and the trap sequencer.
// The slave modport is the sequencer's view; the master modport is the view of the core that drives it.
interface msrv32_trap_sequencer_if #(
  parameter int NUM_LIRQ = 4
);
  localparam int LW = (NUM_LIRQ > 0) ? NUM_LIRQ : 1;

  logic          illegal_instr_in;
  logic          misaligned_load_in;
  logic          misaligned_store_in;
  logic          misaligned_instr_in;
  logic [4:0]    opcode_6_to_2_in;
  logic [2:0]    funct3_in;
  logic [6:0]    funct7_in;
  logic [4:0]    rs1_addr_in;
  logic [4:0]    rs2_addr_in;
  logic [4:0]    rd_addr_in;
  logic          mie_in;
  logic          meie_in;
  logic          mtie_in;
  logic          msie_in;
  logic          meip_in;
  logic          mtip_in;
  logic          msip_in;
  logic [LW-1:0] lie_in;
  logic [LW-1:0] lip_in;

  logic          i_or_e_out;
  logic [4:0]    cause_out;
  logic          set_epc_out;
  logic          set_cause_out;
  logic          mie_clear_out;
  logic          mie_set_out;
  logic          misaligned_exception_out;
  logic          instret_inc_out;
  logic [1:0]    pc_src_out;
  logic          flush_out;
  logic          trap_taken_out;
  logic          stall_out;

  modport slave (
    input  illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in,
           opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
           mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in, lie_in, lip_in,
    output i_or_e_out, cause_out, set_epc_out, set_cause_out, mie_clear_out, mie_set_out,
           misaligned_exception_out, instret_inc_out, pc_src_out, flush_out, trap_taken_out,
           stall_out
  );

  modport master (
    output illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in,
           opcode_6_to_2_in, funct3_in, funct7_in, rs1_addr_in, rs2_addr_in, rd_addr_in,
           mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in, lie_in, lip_in,
    input  i_or_e_out, cause_out, set_epc_out, set_cause_out, mie_clear_out, mie_set_out,
           misaligned_exception_out, instret_inc_out, pc_src_out, flush_out, trap_taken_out,
           stall_out
  );

endinterface

// File: rtl/msrv32_irq_prio_enc.sv
// Fixed-priority interrupt encoder: MEI > MSI > MTI > lirq[0] > ... > lirq[NUM_LIRQ-1].
// Inputs are already qualified by their individual enables; the global mstatus.MIE is applied by the caller.
module msrv32_irq_prio_enc
  import msrv32_trap_pkg::*;
#(
  parameter int NUM_LIRQ = 4,
  parameter int LW       = (NUM_LIRQ > 0) ? NUM_LIRQ : 1
) (
  input  logic          mei,
  input  logic          msi,
  input  logic          mti,
  input  logic [LW-1:0] lirq,
  output logic          valid,
  output logic [4:0]    cause
);

  // Lowest priority is evaluated first so each higher-priority hit overrides it.
  always_comb begin
    valid = 1'b0;
    cause = 5'd0;
    for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
      if (lirq[i]) begin
        valid = 1'b1;
        cause = CAUSE_LIRQ_BASE + 5'(i);
      end
    end
    if (mti) begin
      valid = 1'b1;
      cause = CAUSE_MTI;
    end
    if (msi) begin
      valid = 1'b1;
      cause = CAUSE_MSI;
    end
    if (mei) begin
      valid = 1'b1;
      cause = CAUSE_MEI;
    end
  end

endmodule

// File: rtl/msrv32_trap_sequencer.sv
// Machine-mode trap sequencer: arbitrates interrupts, exceptions, MRET and WFI and sequences
// trap entry (detect, CSR/PC update, handler fetch), trap return and WFI sleep.
module msrv32_trap_sequencer
  import msrv32_trap_pkg::*;
#(
  parameter int NUM_LIRQ = 4,
  parameter bit WFI_EN   = 1'b1
) (
  input logic                    clk_in,
  input logic                    reset_in,
  msrv32_trap_sequencer_if.slave bus
);

  localparam int LW = (NUM_LIRQ > 0) ? NUM_LIRQ : 1;

  trap_state_t state;
  logic        irq_valid, irq_pend, trap_pend;
  logic [4:0]  irq_cause, exc_cause;
  logic        exc_valid, exc_misaligned;
  logic        is_ecall, is_ebreak, is_mret, is_wfi, wfi_sleep;
  logic        i_or_e_q, misaligned_q;
  logic [4:0]  cause_q;

  msrv32_irq_prio_enc #(.NUM_LIRQ(NUM_LIRQ), .LW(LW)) u_irq_prio_enc (
    .mei   (bus.meip_in & bus.meie_in),
    .msi   (bus.msip_in & bus.msie_in),
    .mti   (bus.mtip_in & bus.mtie_in),
    .lirq  (bus.lip_in & bus.lie_in),
    .valid (irq_valid),
    .cause (irq_cause)
  );

  assign is_ecall  = is_priv_instr(bus.opcode_6_to_2_in, bus.funct3_in, bus.funct7_in, bus.rs1_addr_in,
                                   bus.rs2_addr_in, bus.rd_addr_in, FUNCT7_ECALL, RS2_ECALL);
  assign is_ebreak = is_priv_instr(bus.opcode_6_to_2_in, bus.funct3_in, bus.funct7_in, bus.rs1_addr_in,
                                   bus.rs2_addr_in, bus.rd_addr_in, FUNCT7_ECALL, RS2_EBREAK);
  assign is_mret   = is_priv_instr(bus.opcode_6_to_2_in, bus.funct3_in, bus.funct7_in, bus.rs1_addr_in,
                                   bus.rs2_addr_in, bus.rd_addr_in, FUNCT7_MRET, RS2_MRET);
  assign is_wfi    = is_priv_instr(bus.opcode_6_to_2_in, bus.funct3_in, bus.funct7_in, bus.rs1_addr_in,
                                   bus.rs2_addr_in, bus.rd_addr_in, FUNCT7_WFI, RS2_WFI);

  // Wake-up ignores mstatus.MIE, so a WFI with something already pending never sleeps.
  assign irq_pend  = bus.mie_in & irq_valid;
  assign trap_pend = irq_pend | exc_valid;
  assign wfi_sleep = WFI_EN && is_wfi && !irq_valid;

  always_comb begin
    exc_valid      = 1'b1;
    exc_misaligned = 1'b0;
    exc_cause      = 5'd0;
    if (bus.misaligned_instr_in) begin
      exc_cause      = CAUSE_INSTR_MISALIGNED;
      exc_misaligned = 1'b1;
    end else if (bus.illegal_instr_in) begin
      exc_cause = CAUSE_ILLEGAL_INSTR;
    end else if (is_ebreak) begin
      exc_cause = CAUSE_BREAKPOINT;
    end else if (is_ecall) begin
      exc_cause = CAUSE_ECALL_M;
    end else if (bus.misaligned_load_in) begin
      exc_cause      = CAUSE_LOAD_MISALIGNED;
      exc_misaligned = 1'b1;
    end else if (bus.misaligned_store_in) begin
      exc_cause      = CAUSE_STORE_MISALIGNED;
      exc_misaligned = 1'b1;
    end else begin
      exc_valid = 1'b0;
    end
  end

  // Cause fields latch only on the detect edge, so later pending changes cannot disturb them.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state        <= ST_RESET;
      cause_q      <= 5'd0;
      i_or_e_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      case (state)
        ST_RESET: state <= ST_OPERATING;
        ST_OPERATING: begin
          if (trap_pend) begin
            state        <= ST_TRAP_TAKEN;
            i_or_e_q     <= irq_pend;
            cause_q      <= irq_pend ? irq_cause : exc_cause;
            misaligned_q <= !irq_pend && exc_misaligned;
          end else if (is_mret) begin
            state <= ST_TRAP_RETURN;
          end else if (wfi_sleep) begin
            state <= ST_WFI_SLEEP;
          end
        end
        ST_TRAP_TAKEN, ST_TRAP_RETURN: state <= ST_OPERATING;
        ST_WFI_SLEEP: begin
          if (irq_valid) begin
            if (bus.mie_in) begin
              state        <= ST_TRAP_TAKEN;
              i_or_e_q     <= 1'b1;
              cause_q      <= irq_cause;
              misaligned_q <= 1'b0;
            end else begin
              state <= ST_OPERATING;
            end
          end
        end
        default: state <= ST_RESET;
      endcase
    end
  end

  always_comb begin
    bus.pc_src_out      = PC_SRC_NEXT;
    bus.flush_out       = 1'b0;
    bus.trap_taken_out  = 1'b0;
    bus.instret_inc_out = 1'b0;
    bus.stall_out       = 1'b0;
    bus.set_epc_out     = 1'b0;
    bus.set_cause_out   = 1'b0;
    bus.mie_clear_out   = 1'b0;
    bus.mie_set_out     = 1'b0;
    case (state)
      ST_OPERATING: begin
        if (trap_pend) begin
          bus.trap_taken_out = 1'b1;
          bus.flush_out      = 1'b1;
        end else if (is_mret) begin
          bus.flush_out = 1'b1;
        end else if (!wfi_sleep) begin
          bus.instret_inc_out = 1'b1;
        end
      end
      ST_TRAP_TAKEN: begin
        bus.set_epc_out   = 1'b1;
        bus.set_cause_out = 1'b1;
        bus.mie_clear_out = 1'b1;
        bus.pc_src_out    = PC_SRC_TRAP;
        bus.flush_out     = 1'b1;
      end
      ST_TRAP_RETURN: begin
        bus.mie_set_out     = 1'b1;
        bus.pc_src_out      = PC_SRC_EPC;
        bus.flush_out       = 1'b1;
        bus.instret_inc_out = 1'b1;
      end
      ST_WFI_SLEEP: begin
        bus.stall_out = 1'b1;
        if (irq_valid) begin
          if (bus.mie_in) begin
            bus.trap_taken_out = 1'b1;
            bus.flush_out      = 1'b1;
          end else begin
            bus.instret_inc_out = 1'b1;
          end
        end
      end
      default: begin
        bus.pc_src_out = PC_SRC_BOOT;
        bus.flush_out  = 1'b1;
      end
    endcase
  end

  assign bus.cause_out                = cause_q;
  assign bus.i_or_e_out               = i_or_e_q;
  assign bus.misaligned_exception_out = misaligned_q;

endmodule

// File: tb/tb_msrv32_trap_sequencer.sv
// Directed bench for msrv32_trap_sequencer: reset, exception and interrupt priority, MRET, WFI and
// reset during trap/WFI, with hand-computed expected outputs.
module tb_msrv32_trap_sequencer;

  logic clk_in = 1'b0;
  logic reset_in;
  int   checks = 0;
  int   errors = 0;

  always #5 clk_in = ~clk_in;

  msrv32_trap_sequencer_if #(.NUM_LIRQ(4)) bus ();

  msrv32_trap_sequencer #(.NUM_LIRQ(4), .WFI_EN(1'b1)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  task automatic clear_inputs();
    bus.illegal_instr_in    = 1'b0;
    bus.misaligned_load_in  = 1'b0;
    bus.misaligned_store_in = 1'b0;
    bus.misaligned_instr_in = 1'b0;
    bus.opcode_6_to_2_in    = 5'b00100;
    bus.funct3_in           = 3'd0;
    bus.funct7_in           = 7'd0;
    bus.rs1_addr_in         = 5'd0;
    bus.rs2_addr_in         = 5'd0;
    bus.rd_addr_in          = 5'd0;
    bus.mie_in              = 1'b0;
    bus.meie_in             = 1'b0;
    bus.mtie_in             = 1'b0;
    bus.msie_in             = 1'b0;
    bus.meip_in             = 1'b0;
    bus.mtip_in             = 1'b0;
    bus.msip_in             = 1'b0;
    bus.lie_in              = 4'd0;
    bus.lip_in              = 4'd0;
  endtask

  task automatic set_sys(input logic [6:0] f7, input logic [4:0] rs2);
    bus.opcode_6_to_2_in = 5'b11100;
    bus.funct3_in        = 3'd0;
    bus.funct7_in        = f7;
    bus.rs1_addr_in      = 5'd0;
    bus.rd_addr_in       = 5'd0;
    bus.rs2_addr_in      = rs2;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk_in);
    checks++; if (bus.pc_src_out !== 2'b00) begin errors++; $display("FAIL rst_pc_src got %b want 00", bus.pc_src_out); end
    checks++; if (bus.flush_out !== 1'b1) begin errors++; $display("FAIL rst_flush got %b want 1", bus.flush_out); end
    checks++; if ({bus.instret_inc_out, bus.stall_out, bus.set_epc_out, bus.mie_set_out} !== 4'b0000) begin errors++; $display("FAIL rst_strobes got %b want 0000", {bus.instret_inc_out, bus.stall_out, bus.set_epc_out, bus.mie_set_out}); end
    checks++; if ({bus.cause_out, bus.i_or_e_out, bus.misaligned_exception_out} !== 7'd0) begin errors++; $display("FAIL rst_regs got %h want 0", {bus.cause_out, bus.i_or_e_out, bus.misaligned_exception_out}); end
    reset_in = 1'b0;
    #1;
    checks++; if ({bus.pc_src_out, bus.flush_out} !== 3'b001) begin errors++; $display("FAIL rel_boot got %b want 001", {bus.pc_src_out, bus.flush_out}); end
    @(negedge clk_in);
    checks++; if ({bus.pc_src_out, bus.instret_inc_out, bus.flush_out} !== 4'b1110) begin errors++; $display("FAIL oper_entry got %b want 1110", {bus.pc_src_out, bus.instret_inc_out, bus.flush_out}); end
  endtask

  task automatic test_illegal();
    @(negedge clk_in);
    clear_inputs();
    bus.illegal_instr_in = 1'b1;
    #1;
    checks++; if ({bus.trap_taken_out, bus.flush_out, bus.instret_inc_out, bus.pc_src_out} !== 5'b11011) begin errors++; $display("FAIL ill_detect got %b want 11011", {bus.trap_taken_out, bus.flush_out, bus.instret_inc_out, bus.pc_src_out}); end
    @(negedge clk_in);
    clear_inputs();
    #1;
    checks++; if (bus.cause_out !== 5'd2) begin errors++; $display("FAIL ill_cause got %0d want 2", bus.cause_out); end
    checks++; if (bus.i_or_e_out !== 1'b0) begin errors++; $display("FAIL ill_i_or_e got %b want 0", bus.i_or_e_out); end
    checks++; if ({bus.set_epc_out, bus.set_cause_out, bus.mie_clear_out, bus.pc_src_out, bus.trap_taken_out} !== 6'b111100) begin errors++; $display("FAIL ill_update got %b want 111100", {bus.set_epc_out, bus.set_cause_out, bus.mie_clear_out, bus.pc_src_out, bus.trap_taken_out}); end
    @(negedge clk_in);
    checks++; if ({bus.instret_inc_out, bus.pc_src_out, bus.cause_out} !== {1'b1, 2'b11, 5'd2}) begin errors++; $display("FAIL ill_after got %b want 1_11_00010", {bus.instret_inc_out, bus.pc_src_out, bus.cause_out}); end
  endtask

  task automatic test_exc_priority();
    logic [5:0] vec [6];
    logic [4:0] exp_cause [6];
    logic       exp_mis [6];
    // vec bits: misaligned_instr, illegal, ebreak, ecall, misaligned_load, misaligned_store
    vec       = '{6'b000001, 6'b000011, 6'b000110, 6'b001010, 6'b011000, 6'b110000};
    exp_cause = '{5'd6, 5'd4, 5'd11, 5'd3, 5'd2, 5'd0};
    exp_mis   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      clear_inputs();
      bus.misaligned_instr_in = vec[k][5];
      bus.illegal_instr_in    = vec[k][4];
      if (vec[k][3]) set_sys(7'd0, 5'd1);
      else if (vec[k][2]) set_sys(7'd0, 5'd0);
      bus.misaligned_load_in  = vec[k][1];
      bus.misaligned_store_in = vec[k][0];
      #1;
      checks++; if (bus.trap_taken_out !== 1'b1) begin errors++; $display("FAIL exc%0d_detect got %b want 1", k, bus.trap_taken_out); end
      @(negedge clk_in);
      clear_inputs();
      #1;
      checks++; if (bus.cause_out !== exp_cause[k]) begin errors++; $display("FAIL exc%0d_cause got %0d want %0d", k, bus.cause_out, exp_cause[k]); end
      checks++; if ({bus.i_or_e_out, bus.misaligned_exception_out} !== {1'b0, exp_mis[k]}) begin errors++; $display("FAIL exc%0d_flags got %b want 0%b", k, {bus.i_or_e_out, bus.misaligned_exception_out}, exp_mis[k]); end
    end
  endtask

  task automatic test_irq_priority();
    logic [2:0] core [5];
    logic [3:0] lirq [5];
    logic [4:0] exp_cause [5];
    // core bits: MEI, MSI, MTI (pending and enabled together)
    core      = '{3'b001, 3'b111, 3'b011, 3'b000, 3'b000};
    lirq      = '{4'b0100, 4'b1111, 4'b0000, 4'b1010, 4'b1000};
    exp_cause = '{5'd7, 5'd11, 5'd3, 5'd17, 5'd19};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      clear_inputs();
      bus.mie_in  = 1'b1;
      {bus.meip_in, bus.msip_in, bus.mtip_in} = core[k];
      {bus.meie_in, bus.msie_in, bus.mtie_in} = core[k];
      bus.lip_in  = lirq[k];
      bus.lie_in  = lirq[k];
      bus.misaligned_load_in = (k == 0);
      #1;
      checks++; if (bus.trap_taken_out !== 1'b1) begin errors++; $display("FAIL irq%0d_detect got %b want 1", k, bus.trap_taken_out); end
      @(negedge clk_in);
      clear_inputs();
      bus.mie_in  = 1'b1;
      bus.meip_in = 1'b1;
      bus.meie_in = 1'b1;
      #1;
      checks++; if (bus.cause_out !== exp_cause[k]) begin errors++; $display("FAIL irq%0d_cause got %0d want %0d", k, bus.cause_out, exp_cause[k]); end
      checks++; if ({bus.i_or_e_out, bus.misaligned_exception_out, bus.pc_src_out} !== 4'b1010) begin errors++; $display("FAIL irq%0d_flags got %b want 1010", k, {bus.i_or_e_out, bus.misaligned_exception_out, bus.pc_src_out}); end
      clear_inputs();
    end
    @(negedge clk_in);
    clear_inputs();
    bus.mtip_in = 1'b1;
    bus.mtie_in = 1'b1;
    #1;
    checks++; if ({bus.trap_taken_out, bus.instret_inc_out} !== 2'b01) begin errors++; $display("FAIL irq_masked got %b want 01", {bus.trap_taken_out, bus.instret_inc_out}); end
    bus.mie_in  = 1'b1;
    bus.mtie_in = 1'b0;
    #1;
    checks++; if ({bus.trap_taken_out, bus.instret_inc_out} !== 2'b01) begin errors++; $display("FAIL irq_disabled got %b want 01", {bus.trap_taken_out, bus.instret_inc_out}); end
    clear_inputs();
  endtask

  task automatic test_mret();
    @(negedge clk_in);
    clear_inputs();
    set_sys(7'b0011000, 5'd2);
    #1;
    checks++; if ({bus.flush_out, bus.instret_inc_out, bus.trap_taken_out} !== 3'b100) begin errors++; $display("FAIL mret_detect got %b want 100", {bus.flush_out, bus.instret_inc_out, bus.trap_taken_out}); end
    @(negedge clk_in);
    clear_inputs();
    #1;
    checks++; if ({bus.mie_set_out, bus.pc_src_out, bus.instret_inc_out, bus.flush_out, bus.set_epc_out} !== 6'b101110) begin errors++; $display("FAIL mret_return got %b want 101110", {bus.mie_set_out, bus.pc_src_out, bus.instret_inc_out, bus.flush_out, bus.set_epc_out}); end
    @(negedge clk_in);
    set_sys(7'b0011000, 5'd2);
    bus.mie_in  = 1'b1;
    bus.meip_in = 1'b1;
    bus.meie_in = 1'b1;
    #1;
    checks++; if (bus.trap_taken_out !== 1'b1) begin errors++; $display("FAIL mret_irq_detect got %b want 1", bus.trap_taken_out); end
    @(negedge clk_in);
    clear_inputs();
    #1;
    checks++; if ({bus.cause_out, bus.i_or_e_out, bus.mie_set_out, bus.set_epc_out} !== {5'd11, 3'b101}) begin errors++; $display("FAIL mret_irq got %b want 01011_101", {bus.cause_out, bus.i_or_e_out, bus.mie_set_out, bus.set_epc_out}); end
  endtask

  task automatic test_wfi();
    @(negedge clk_in);
    clear_inputs();
    set_sys(7'b0001000, 5'd5);
    #1;
    checks++; if ({bus.instret_inc_out, bus.stall_out, bus.trap_taken_out} !== 3'b000) begin errors++; $display("FAIL wfi_enter got %b want 000", {bus.instret_inc_out, bus.stall_out, bus.trap_taken_out}); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      checks++; if ({bus.stall_out, bus.instret_inc_out, bus.trap_taken_out} !== 3'b100) begin errors++; $display("FAIL wfi_sleep%0d got %b want 100", c, {bus.stall_out, bus.instret_inc_out, bus.trap_taken_out}); end
    end
    bus.lip_in = 4'b0001;
    bus.lie_in = 4'b0001;
    #1;
    checks++; if ({bus.instret_inc_out, bus.trap_taken_out} !== 2'b10) begin errors++; $display("FAIL wfi_wake got %b want 10", {bus.instret_inc_out, bus.trap_taken_out}); end
    @(negedge clk_in);
    checks++; if ({bus.stall_out, bus.trap_taken_out, bus.set_epc_out, bus.cause_out} !== {3'b000, 5'd11}) begin errors++; $display("FAIL wfi_exit got %b want 000_01011", {bus.stall_out, bus.trap_taken_out, bus.set_epc_out, bus.cause_out}); end
    clear_inputs();
    @(negedge clk_in);
    set_sys(7'b0001000, 5'd5);
    bus.mie_in = 1'b1;
    repeat (3) @(negedge clk_in);
    checks++; if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL wfi_mie_sleep got %b want 1", bus.stall_out); end
    bus.lip_in = 4'b0001;
    bus.lie_in = 4'b0001;
    #1;
    checks++; if ({bus.trap_taken_out, bus.flush_out, bus.instret_inc_out} !== 3'b110) begin errors++; $display("FAIL wfi_irq_detect got %b want 110", {bus.trap_taken_out, bus.flush_out, bus.instret_inc_out}); end
    @(negedge clk_in);
    clear_inputs();
    #1;
    checks++; if ({bus.cause_out, bus.i_or_e_out, bus.set_epc_out, bus.stall_out} !== {5'd16, 3'b110}) begin errors++; $display("FAIL wfi_irq got %b want 10000_110", {bus.cause_out, bus.i_or_e_out, bus.set_epc_out, bus.stall_out}); end
    @(negedge clk_in);
    set_sys(7'b0001000, 5'd5);
    bus.lip_in = 4'b0010;
    bus.lie_in = 4'b0010;
    #1;
    checks++; if ({bus.instret_inc_out, bus.trap_taken_out} !== 2'b10) begin errors++; $display("FAIL wfi_nosleep got %b want 10", {bus.instret_inc_out, bus.trap_taken_out}); end
    @(negedge clk_in);
    checks++; if (bus.stall_out !== 1'b0) begin errors++; $display("FAIL wfi_nosleep_stall got %b want 0", bus.stall_out); end
    clear_inputs();
  endtask

  task automatic test_reset_midflight();
    @(negedge clk_in);
    clear_inputs();
    bus.illegal_instr_in = 1'b1;
    @(negedge clk_in);
    clear_inputs();
    checks++; if (bus.set_epc_out !== 1'b1) begin errors++; $display("FAIL rtrap_in_trap got %b want 1", bus.set_epc_out); end
    reset_in = 1'b1;
    @(negedge clk_in);
    checks++; if ({bus.cause_out, bus.stall_out, bus.set_epc_out, bus.pc_src_out, bus.flush_out} !== {5'd0, 5'b00001}) begin errors++; $display("FAIL rtrap_reset got %b want 00000_00001", {bus.cause_out, bus.stall_out, bus.set_epc_out, bus.pc_src_out, bus.flush_out}); end
    reset_in = 1'b0;
    @(negedge clk_in);
    bus.misaligned_store_in = 1'b1;
    @(negedge clk_in);
    clear_inputs();
    checks++; if (bus.cause_out !== 5'd6) begin errors++; $display("FAIL rwfi_pre_cause got %0d want 6", bus.cause_out); end
    @(negedge clk_in);
    set_sys(7'b0001000, 5'd5);
    @(negedge clk_in);
    checks++; if (bus.stall_out !== 1'b1) begin errors++; $display("FAIL rwfi_sleep got %b want 1", bus.stall_out); end
    reset_in = 1'b1;
    @(negedge clk_in);
    checks++; if ({bus.cause_out, bus.stall_out, bus.misaligned_exception_out, bus.pc_src_out} !== 9'd0) begin errors++; $display("FAIL rwfi_reset got %b want 0", {bus.cause_out, bus.stall_out, bus.misaligned_exception_out, bus.pc_src_out}); end
    reset_in = 1'b0;
    clear_inputs();
    @(negedge clk_in);
    checks++; if ({bus.pc_src_out, bus.instret_inc_out, bus.stall_out} !== 4'b1110) begin errors++; $display("FAIL rwfi_resume got %b want 1110", {bus.pc_src_out, bus.instret_inc_out, bus.stall_out}); end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_exc_priority();
    test_irq_priority();
    test_mret();
    test_wfi();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
